// File: rtl/cpu_state_monitor.sv
// cpu_state_monitor: commit-time exception classifier and core run-state FSM.
// Drives PC write enable, trap redirect, cause/EPC capture and event counters.
module cpu_state_monitor #(
    parameter int                    NUM_EXC     = 8,
    parameter int                    DATA_WIDTH  = 64,
    parameter logic [NUM_EXC-1:0]    FATAL_MASK  = 8'b0000_0111,
    parameter logic [NUM_EXC-1:0]    TRAP_MASK   = 8'b0000_1000,
    parameter logic [NUM_EXC-1:0]    HALT_MASK   = 8'b0001_0000,
    parameter logic [DATA_WIDTH-1:0] TRAP_VECTOR = 64'h8000_0100,
    parameter int                    CNT_W       = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       valid_i,
    input  logic [NUM_EXC-1:0]         exceptions_i,
    input  logic [DATA_WIDTH-1:0]      commit_pc_i,
    input  logic                       resume_i,
    input  logic                       clear_i,
    output logic [2:0]                 state_o,
    output logic                       pc_we_o,
    output logic                       redirect_valid_o,
    output logic [DATA_WIDTH-1:0]      redirect_pc_o,
    output logic [$clog2(NUM_EXC)-1:0] cause_o,
    output logic [DATA_WIDTH-1:0]      epc_o,
    output logic [CNT_W-1:0]           trap_count_o,
    output logic [CNT_W-1:0]           halt_count_o
);

    localparam int CW = $clog2(NUM_EXC);

    typedef enum logic [2:0] {
        S_RST    = 3'd0,
        S_NORMAL = 3'd1,
        S_HALT   = 3'd2,
        S_ERROR  = 3'd3,
        S_TRAP   = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [CW-1:0]           r_cause;
    logic [DATA_WIDTH-1:0]   r_epc;
    logic [CNT_W-1:0]        r_trap_cnt;
    logic [CNT_W-1:0]        r_halt_cnt;

    logic [NUM_EXC-1:0]      w_fatal;
    logic [NUM_EXC-1:0]      w_trap;
    logic [NUM_EXC-1:0]      w_halt;
    logic                    w_latch;
    logic [CW-1:0]           w_cause;
    logic                    w_trap_entry;
    logic                    w_trap_sat;
    logic                    w_halt_sat;

    // Lowest set index wins inside a class.
    function automatic logic [CW-1:0] lowest_idx(
        input logic [NUM_EXC-1:0] v
    );
        logic [CW-1:0] idx;
        idx = '0;
        for (int i = NUM_EXC - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = CW'(i);
            end
        end
        return idx;
    endfunction

    assign w_fatal = exceptions_i & FATAL_MASK;
    assign w_trap  = exceptions_i & TRAP_MASK;
    assign w_halt  = exceptions_i & HALT_MASK;

    // Next-state decode; exceptions only matter in NORMAL with a valid commit.
    always_comb begin
        w_next  = r_state;
        w_latch = 1'b0;
        w_cause = '0;
        unique case (r_state)
            S_RST: begin
                w_next = S_NORMAL;
            end
            S_NORMAL: begin
                if (valid_i) begin
                    if (|w_fatal) begin
                        w_next  = S_ERROR;
                        w_latch = 1'b1;
                        w_cause = lowest_idx(w_fatal);
                    end else if (|w_trap) begin
                        w_next  = S_TRAP;
                        w_latch = 1'b1;
                        w_cause = lowest_idx(w_trap);
                    end else if (|w_halt) begin
                        w_next  = S_HALT;
                        w_latch = 1'b1;
                        w_cause = lowest_idx(w_halt);
                    end
                end
            end
            S_TRAP: begin
                w_next = S_NORMAL;
            end
            S_HALT: begin
                if (resume_i) begin
                    w_next = S_NORMAL;
                end
            end
            S_ERROR: begin
                if (clear_i) begin
                    w_next = S_RST;
                end
            end
            default: begin
                w_next = S_ERROR;
            end
        endcase
    end

    assign w_trap_entry = (r_state == S_NORMAL) && (w_next == S_TRAP);
    assign w_trap_sat   = &r_trap_cnt;
    assign w_halt_sat   = &r_halt_cnt;

    // Run-state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_RST;
        end else begin
            r_state <= w_next;
        end
    end

    // Cause and EPC capture on the edge that leaves NORMAL for an exception.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cause <= '0;
            r_epc   <= '0;
        end else if (w_latch) begin
            r_cause <= w_cause;
            r_epc   <= commit_pc_i;
        end
    end

    // Saturating count of traps taken, bumped on TRAP entry.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_trap_cnt <= '0;
        end else if (w_trap_entry && !w_trap_sat) begin
            r_trap_cnt <= r_trap_cnt + CNT_W'(1);
        end
    end

    // Saturating count of cycles spent halted.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_halt_cnt <= '0;
        end else if ((r_state == S_HALT) && !w_halt_sat) begin
            r_halt_cnt <= r_halt_cnt + CNT_W'(1);
        end
    end

    assign state_o          = r_state;
    assign pc_we_o          = (r_state == S_NORMAL);
    assign redirect_valid_o = (r_state == S_TRAP);
    assign redirect_pc_o    = redirect_valid_o ? TRAP_VECTOR : '0;
    assign cause_o          = r_cause;
    assign epc_o            = r_epc;
    assign trap_count_o     = r_trap_cnt;
    assign halt_count_o     = r_halt_cnt;

endmodule

// File: tb/tb_cpu_state_monitor.sv
// tb_cpu_state_monitor: scoreboard bench for cpu_state_monitor.
// Directed vectors push expected snapshots; a negedge monitor pops and compares.
module tb_cpu_state_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid = 1'b1;
    logic [7:0]  exc = '0;
    logic [63:0] cpc = '0;
    logic        res = 1'b0;
    logic        clr = 1'b0;
    logic [2:0]  st;
    logic        pcwe;
    logic        rv;
    logic [63:0] rpc;
    logic [2:0]  cause;
    logic [63:0] epc;
    logic [15:0] tc;
    logic [15:0] hc;

    logic        rst2 = 1'b0;
    logic        valid2 = 1'b1;
    logic [7:0]  exc2 = '0;
    logic [2:0]  st2;
    logic        pcwe2;
    logic        rv2;
    logic [63:0] rpc2;
    logic [2:0]  cause2;
    logic [63:0] epc2;
    logic [3:0]  tc2;
    logic [3:0]  hc2;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [2:0]  st;
        logic [2:0]  cause;
        logic [63:0] epc;
        logic [15:0] tc;
        logic [15:0] hc;
    } exp_t;

    exp_t       q[$];
    logic [3:0] q2[$];

    always #5 clk = ~clk;

    cpu_state_monitor dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid),
        .exceptions_i(exc), .commit_pc_i(cpc),
        .resume_i(res), .clear_i(clr),
        .state_o(st), .pc_we_o(pcwe),
        .redirect_valid_o(rv), .redirect_pc_o(rpc),
        .cause_o(cause), .epc_o(epc),
        .trap_count_o(tc), .halt_count_o(hc)
    );

    cpu_state_monitor #(.CNT_W(4)) dut2 (
        .clk_i(clk), .rst_i(rst2), .valid_i(valid2),
        .exceptions_i(exc2), .commit_pc_i(64'h0),
        .resume_i(1'b0), .clear_i(1'b0),
        .state_o(st2), .pc_we_o(pcwe2),
        .redirect_valid_o(rv2), .redirect_pc_o(rpc2),
        .cause_o(cause2), .epc_o(epc2),
        .trap_count_o(tc2), .halt_count_o(hc2)
    );

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Monitor: compare every pending expectation against the DUT outputs.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("state", 64'(st), 64'(e.st));
            chk("pc_we", 64'(pcwe), 64'(e.st == 3'd1));
            chk("redir_valid", 64'(rv), 64'(e.st == 3'd4));
            chk("redir_pc", rpc, (e.st == 3'd4) ? 64'h8000_0100 : 64'h0);
            chk("cause", 64'(cause), 64'(e.cause));
            chk("epc", epc, e.epc);
            chk("trap_count", 64'(tc), 64'(e.tc));
            chk("halt_count", 64'(hc), 64'(e.hc));
        end
        if (q2.size() > 0) begin
            logic [3:0] t;
            t = q2.pop_front();
            chk("sat_trap_count", 64'(tc2), 64'(t));
        end
    end

    task automatic push(input logic [2:0] s, input logic [2:0] c,
                        input logic [63:0] e, input logic [15:0] t,
                        input logic [15:0] h);
        exp_t x;
        x.st = s; x.cause = c; x.epc = e; x.tc = t; x.hc = h;
        q.push_back(x);
    endtask

    task automatic cyc(input logic v, input logic [7:0] x,
                       input logic [63:0] p, input logic r,
                       input logic cl, input logic [2:0] s,
                       input logic [2:0] c, input logic [63:0] e,
                       input logic [15:0] t, input logic [15:0] h);
        @(negedge clk);
        valid = v; exc = x; cpc = p; res = r; clr = cl;
        @(posedge clk);
        push(s, c, e, t, h);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst = 1'b1; rst2 = 1'b1;
        push(0, 0, 0, 0, 0);
        #7 rst = 1'b0;
        for (int i = 0; i < 3; i++)
            cyc(1, 8'h00, 64'h0, 0, 0, 1, 0, 64'h0, 0, 0);
        cyc(1, 8'hE0, 64'h1234, 0, 1, 1, 0, 64'h0, 0, 0);
        cyc(1, 8'h08, 64'h8000_0010, 0, 0, 4, 3, 64'h8000_0010, 1, 0);
        cyc(1, 8'h00, 64'h0, 0, 0, 1, 3, 64'h8000_0010, 1, 0);
        cyc(1, 8'h10, 64'h8000_0020, 0, 0, 2, 4, 64'h8000_0020, 1, 0);
        for (int k = 1; k <= 5; k++)
            cyc(1, 8'h09, 64'h9999, 0, 1, 2, 4, 64'h8000_0020, 1, 16'(k));
        cyc(1, 8'h00, 64'h0, 1, 0, 1, 4, 64'h8000_0020, 1, 6);
        cyc(1, 8'h18, 64'h8000_0028, 0, 0, 4, 3, 64'h8000_0028, 2, 6);
        cyc(1, 8'h00, 64'h0, 0, 0, 1, 3, 64'h8000_0028, 2, 6);
        cyc(1, 8'h0E, 64'h8000_0030, 0, 0, 3, 1, 64'h8000_0030, 2, 6);
        cyc(1, 8'h00, 64'h0, 1, 0, 3, 1, 64'h8000_0030, 2, 6);
        cyc(1, 8'h08, 64'h5, 0, 0, 3, 1, 64'h8000_0030, 2, 6);
        cyc(1, 8'h00, 64'h0, 0, 1, 0, 1, 64'h8000_0030, 2, 6);
        cyc(1, 8'h00, 64'h0, 0, 0, 1, 1, 64'h8000_0030, 2, 6);
        cyc(0, 8'h08, 64'h8000_0040, 0, 0, 1, 1, 64'h8000_0030, 2, 6);
        cyc(1, 8'h18, 64'h8000_0050, 0, 0, 4, 3, 64'h8000_0050, 3, 6);
        @(negedge clk);
        valid = 1; exc = 0; cpc = 0;
        #2 rst = 1'b1;
        #1;
        chk("async_rst_redir", 64'(rv), 64'h0);
        chk("async_rst_state", 64'(st), 64'h0);
        chk("async_rst_tc", 64'(tc), 64'h0);
        chk("async_rst_epc", epc, 64'h0);
        #1 rst = 1'b0;
        cyc(1, 8'h00, 64'h0, 0, 0, 1, 0, 64'h0, 0, 0);

        #3 rst2 = 1'b0;
        @(negedge clk);
        exc2 = 8'h00;
        @(posedge clk);
        for (int i = 1; i <= 18; i++) begin
            @(negedge clk);
            exc2 = 8'h08;
            @(posedge clk);
            q2.push_back((i > 15) ? 4'hF : 4'(i));
            @(negedge clk);
            exc2 = 8'h00;
            @(posedge clk);
        end
        @(negedge clk);
        #1;
        chk("queues_drained", 64'(q.size() + q2.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_state_monitor.md
Name: cpu_state_monitor

Overview:
Parametrised successor to the top-level run-state monitor. Classifies N commit-time exception bits into fatal, trap and halt classes using mask parameters, and prioritises them. Drives the core run state RST/NORMAL/TRAP/HALT/ERROR, the PC write enable and a one-cycle trap redirect. Latches cause and EPC, supports debugger resume and error clear, and keeps saturating event counters. Sits between CPU (exceptions_o, commit_pc_o) and PC (ewrite_i, data_i mux).

Parameters:
NUM_EXC, 8, number of exception bits (>=2)
DATA_WIDTH, 64, PC/EPC width
FATAL_MASK, 8'b0000_0111, bits forcing ERROR (width NUM_EXC)
TRAP_MASK, 8'b0000_1000, bits taking a trap (ECALL)
HALT_MASK, 8'b0001_0000, bits halting the core (EBREAK)
TRAP_VECTOR, 64'h8000_0100, redirect target on trap
CNT_W, 16, event counter width

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
valid_i  in  1  commit valid; exceptions_i/commit_pc_i sampled only when high
exceptions_i  in  NUM_EXC  exception bits of committing instruction
commit_pc_i  in  DATA_WIDTH  PC of committing instruction
resume_i  in  1  debugger resume request (HALT exit)
clear_i  in  1  error clear request (ERROR exit)
state_o  out  3  RST=0 NORMAL=1 HALT=2 ERROR=3 TRAP=4
pc_we_o  out  1  PC write enable
redirect_valid_o  out  1  trap redirect pulse
redirect_pc_o  out  DATA_WIDTH  redirect target
cause_o  out  $clog2(NUM_EXC)  index of last taken exception
epc_o  out  DATA_WIDTH  commit PC of last taken exception
trap_count_o  out  CNT_W  traps taken, saturating
halt_count_o  out  CNT_W  cycles spent in HALT, saturating

Behaviour:
- Reset, async: state=RST, pc_we_o=0, redirect_valid_o=0, cause_o=0, epc_o=0, counters=0. All outputs registered or decoded from state/registers only; no combinational path from inputs to outputs.
- pc_we_o = (state==NORMAL). redirect_valid_o = (state==TRAP). redirect_pc_o = TRAP_VECTOR when redirect_valid_o=1, else 0.
- Classify: F = exceptions_i & FATAL_MASK; T = exceptions_i & TRAP_MASK; H = exceptions_i & HALT_MASK. Bits in no mask are ignored.
- Priority: F over T over H. Within a class, the lowest set index wins.
- RST: goes to NORMAL on the first clock edge after rst_i deasserts.
- NORMAL: with valid_i=1:
  - F!=0 -> ERROR.
  - else T!=0 -> TRAP.
  - else H!=0 -> HALT.
  - else stay in NORMAL.
  - On any of the three transitions, latch cause_o=winning index and epc_o=commit_pc_i on the same edge.
  - With valid_i=0, exceptions are ignored.
- TRAP: exactly one cycle, then NORMAL. trap_count_o increments on entry, saturating at all-ones.
- HALT:
  - resume_i=1 -> NORMAL next cycle.
  - halt_count_o increments every cycle in HALT, saturating.
  - Exceptions are ignored.
- ERROR:
  - Sticky; only clear_i=1 leaves it, to RST. Counters and cause/epc are retained.
  - resume_i is ignored.
- clear_i is ignored outside ERROR; resume_i is ignored outside HALT.
- Simultaneous F and T bits: ERROR wins; cause_o = lowest fatal index.
- Reset mid-TRAP: redirect_valid_o drops immediately (async) and no counter update occurs.
- A counter at all-ones stays at all-ones; no wrap.
- Undefined state encodings (5-7) go to ERROR on the next edge.

Test Plan:
1. Release reset, valid_i=1, exceptions_i=0 for 3 cycles -> state RST then NORMAL, pc_we_o=1 from cycle 1, counters 0.
2. NORMAL, valid_i=1, exceptions_i=8'h08, commit_pc_i=64'h8000_0010 -> next cycle state=TRAP, redirect_valid_o=1, redirect_pc_o=64'h8000_0100, cause_o=3, epc_o=64'h8000_0010, trap_count_o=1; following cycle state=NORMAL, redirect_valid_o=0.
3. exceptions_i=8'h10 -> HALT, cause_o=4; hold 5 cycles -> halt_count_o=5, pc_we_o=0; pulse resume_i -> NORMAL next cycle.
4. exceptions_i=8'h0E (fatal bits 1,2 plus trap bit 3) -> ERROR, cause_o=1; resume_i ignored; clear_i -> RST, then NORMAL; trap_count_o unchanged.
5. exceptions_i=8'h08 with valid_i=0 -> stay NORMAL, no latch; assert rst_i asynchronously during TRAP -> redirect_valid_o=0 before the next edge, state=RST.
6. Force 2^CNT_W+2 traps (CNT_W overridden to 4) -> trap_count_o saturates at 4'hF.
